// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the two-requester nibble-serial adder scheduler.
package adder_sched_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int nibs(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/adder_sched_adder.sv
// Explicit 4-bit ripple-carry adder built from full-adder equations; the shared datapath.
module adder_explicit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/adder_sched_arb.sv
// Two-way round-robin arbiter; the pointer flips away from the owner when an op retires.
module arb_rr2 (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic done,
  input  logic done_id,
  output logic grant0,
  output logic grant1
);

  logic ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (done) begin
      ptr <= ~done_id;
    end
  end

  // The pointer only matters under contention; a lone requester always wins.
  always_comb begin
    grant0 = valid0;
    grant1 = valid1;
    if (valid0 && valid1) begin
      grant0 = ~ptr;
      grant1 = ptr;
    end
  end

endmodule

// File: rtl/adder_sched.sv
// Scheduler top: arbitrates two requesters and runs a WIDTH-bit add one nibble per cycle.
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id
);

  localparam int NIBS = nibs(WIDTH);
  localparam int K_W  = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NIBS - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
    $error("adder_sched: WIDTH must be a positive multiple of 4");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_reg;
  logic             op_cin;
  logic             op_id;
  logic             carry_reg;
  logic [K_W-1:0]   k;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             finish;
  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_cin;
  logic             nib_cout;

  arb_rr2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .done    (finish),
    .done_id (op_id),
    .grant0  (grant0),
    .grant1  (grant1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ready is gated by rst_n so no requester sees an accept while reset is held.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    finish     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        req0_ready = grant0 && rst_n;
        req1_ready = grant1 && rst_n;
        accept     = (grant0 || grant1) && rst_n;
        if (accept) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (k == K_LAST) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        finish    = res_ready;
        if (res_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    nib_a   = op_a[k*NIB_W +: NIB_W];
    nib_b   = op_b[k*NIB_W +: NIB_W];
    nib_cin = (k == '0) ? op_cin : carry_reg;
  end

  adder_explicit u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (nib_cin),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Operands are captured at the handshake so later requester changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      op_id     <= 1'b0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      k         <= '0;
    end else if (accept) begin
      op_a   <= grant1 ? req1_a : req0_a;
      op_b   <= grant1 ? req1_b : req0_b;
      op_cin <= grant1 ? req1_cin : req0_cin;
      op_id  <= grant1;
      k      <= '0;
    end else if (state == S_RUN) begin
      sum_reg[k*NIB_W +: NIB_W] <= nib_sum;
      carry_reg                 <= nib_cout;
      k                         <= (k == K_LAST) ? '0 : k + 1'b1;
    end
  end

  assign res_sum   = sum_reg;
  assign res_carry = carry_reg;
  assign res_id    = op_id;

endmodule

// File: tb/tb_adder_sched.sv
// Scoreboard bench for adder_sched: drivers push expected results, a monitor pops and compares.
module tb_adder_sched;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;
  logic             res_id;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             id;
  } result_t;

  result_t exp_q[$];
  result_t mon_exp;
  int      errors = 0;
  int      checks = 0;

  adder_sched #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_carry  (res_carry),
    .res_id     (res_id)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout expected event", name);
  endtask

  // Monitor: every consumed result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got sum 0x%0h id %0d expected none",
                 res_sum, res_id);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("res_sum", 32'(res_sum), 32'(mon_exp.sum));
        check_output("res_carry", 32'(res_carry), 32'(mon_exp.carry));
        check_output("res_id", 32'(res_id), 32'(mon_exp.id));
      end
    end
  end

  task automatic apply_stimulus(input logic id, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic cin,
                                input logic [WIDTH-1:0] exp_sum, input logic exp_carry,
                                input bit push);
    int n;
    n = 0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      report_timeout("accept");
    end else if (push) begin
      exp_q.push_back('{sum: exp_sum, carry: exp_carry, id: id});
    end
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  // Both requesters stay valid; grants must alternate starting from first_id.
  task automatic contend(input int n_ops, input logic first_id);
    int   accepted;
    int   guard;
    logic exp_next;
    accepted = 0;
    guard    = 0;
    exp_next = first_id;
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b0;
    while (accepted < n_ops && guard < 200) begin
      @(negedge clk);
      guard++;
      if (req0_ready || req1_ready) begin
        check_output("grant", {30'd0, req1_ready, req0_ready}, exp_next ? 32'd2 : 32'd1);
        if (exp_next) exp_q.push_back('{sum: 16'h0000, carry: 1'b1, id: 1'b1});
        else          exp_q.push_back('{sum: 16'h0003, carry: 1'b0, id: 1'b0});
        exp_next = ~exp_next;
        accepted++;
      end
    end
    if (accepted < n_ops) report_timeout("contention_accept");
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      report_timeout("drain");
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    res_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_res_valid", 32'(res_valid), 32'd0);
    check_output("rst_res_sum", 32'(res_sum), 32'd0);
    check_output("rst_res_carry", 32'(res_carry), 32'd0);
    check_output("rst_res_id", 32'(res_id), 32'd0);
    check_output("rst_req0_ready", 32'(req0_ready), 32'd0);
    check_output("rst_req1_ready", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] basic add and latency");
    apply_stimulus(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (res_valid) break;
    end
    check_output("latency", 32'(n), 32'd5);
    drain();

    $display("[TB] carry chain");
    apply_stimulus(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
    drain();
    apply_stimulus(1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1);
    drain();

    $display("[TB] contention");
    contend(4, 1'b0);
    drain();

    $display("[TB] backpressure");
    res_ready = 1'b0;
    apply_stimulus(1'b0, 16'hF0F0, 16'h1111, 1'b1, 16'h0202, 1'b1, 1'b1);
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) report_timeout("backpressure_valid");
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001;
    req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0002;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("hold_valid", 32'(res_valid), 32'd1);
      check_output("hold_sum", 32'(res_sum), 32'h0202);
      check_output("hold_carry", 32'(res_carry), 32'd1);
      check_output("hold_id", 32'(res_id), 32'd0);
      check_output("hold_req0_ready", 32'(req0_ready), 32'd0);
      check_output("hold_req1_ready", 32'(req1_ready), 32'd0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    drain();

    $display("[TB] reset mid-run");
    apply_stimulus(1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midrst_res_valid", 32'(res_valid), 32'd0);
    check_output("midrst_res_sum", 32'(res_sum), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_output("abandoned_valid", 32'(res_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    contend(1, 1'b0);
    drain();
    apply_stimulus(1'b1, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b1);
    drain();

    $display("[TB] operand change after handshake");
    apply_stimulus(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1);
    req0_a   = 16'hFFFF;
    req0_b   = 16'hFFFF;
    req0_cin = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
